// File: rtl/gear_edc_adder.sv
// rtl/gear_edc_adder.sv - GeAr approximate adder with one-fix-per-cycle error correction
// Sub-adders guess carry-in 0; exact mode injects carries lowest-first until no misprediction remains.
module gear_edc_adder #(
    parameter int N = 16,
    parameter int R = 4,
    parameter int P = 4
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [N:1]                  A,
    input  logic [N:1]                  B,
    input  logic                        CIN,
    input  logic                        MODE,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    output logic [N:1]                  SUM,
    output logic                        COUT,
    output logic                        ERR,
    output logic [$clog2((N-P)/R):0]    NCORR,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY
);

    localparam int K  = (N - P) / R;
    localparam int W  = R + P;
    localparam int NW = $clog2(K) + 1;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [N:1]     a_q, a_d, b_q, b_d;
    logic           cin_q, cin_d, mode_q, mode_d;
    logic [K-1:1]   c_q, c_d;
    logic [NW-1:0]  ncorr_q, ncorr_d;
    logic           err_q, err_d;
    logic [N:1]     sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic [K-1:0]   sub_cin;
    logic [W:0]     sub_sum [K];
    logic [N:1]     approx_sum;
    logic [K-1:1]   err_vec;
    logic [K-1:1]   fix;
    logic           found;

    // Sub-adder i covers bits [iR+W : iR+1]; its bit R lands on the next sub-adder's LSB.
    always_comb begin
        sub_cin[0] = cin_q;
        for (int i = 1; i < K; i++) begin
            sub_cin[i] = c_q[i];
        end
        for (int i = 0; i < K; i++) begin
            sub_sum[i] = {1'b0, a_q[i*R+1 +: W]} + {1'b0, b_q[i*R+1 +: W]}
                       + {{W{1'b0}}, sub_cin[i]};
        end
        approx_sum      = '0;
        approx_sum[W:1] = sub_sum[0][W-1:0];
        for (int i = 1; i < K; i++) begin
            approx_sum[i*R+P+1 +: R] = sub_sum[i][W-1:P];
        end
        for (int i = 1; i < K; i++) begin
            err_vec[i] = (sub_sum[i-1][R] ^ a_q[i*R+1] ^ b_q[i*R+1])
                       & (&(a_q[i*R+1 +: P] ^ b_q[i*R+1 +: P]))
                       & ~c_q[i];
        end
        fix   = '0;
        found = 1'b0;
        for (int i = 1; i < K; i++) begin
            if (err_vec[i] && !found) begin
                fix[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        mode_d      = mode_q;
        c_d         = c_q;
        ncorr_d     = ncorr_q;
        err_d       = err_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    a_d        = A;
                    b_d        = B;
                    cin_d      = CIN;
                    mode_d     = MODE;
                    c_d        = '0;
                    ncorr_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_EVAL;
                end
            end
            S_EVAL: begin
                // No correction has happened yet exactly on the first evaluation.
                if (ncorr_q == '0) begin
                    err_d = |err_vec;
                end
                if (mode_q && (|err_vec)) begin
                    c_d     = c_q | fix;
                    ncorr_d = ncorr_q + NW'(1);
                end else begin
                    sum_d       = approx_sum;
                    cout_d      = sub_sum[K-1][W];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            mode_q      <= 1'b0;
            c_q         <= '0;
            ncorr_q     <= '0;
            err_q       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            mode_q      <= mode_d;
            c_q         <= c_d;
            ncorr_q     <= ncorr_d;
            err_q       <= err_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign SUM       = sum_q;
    assign COUT      = cout_q;
    assign ERR       = err_q;
    assign NCORR     = ncorr_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_gear_edc_adder.sv
// tb/tb_gear_edc_adder.sv - directed and randomized checks of gear_edc_adder against an arithmetic model
module tb_gear_edc_adder;

    localparam int N = 16;
    localparam int R = 4;
    localparam int P = 4;
    localparam int K = (N - P) / R;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [N:1]    A = '0;
    logic [N:1]    B = '0;
    logic          CIN = 1'b0;
    logic          MODE = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          OUT_READY = 1'b0;
    logic          IN_READY;
    logic [N:1]    SUM;
    logic          COUT;
    logic          ERR;
    logic [2:0]    NCORR;
    logic          OUT_VALID;

    int checks = 0;
    int passed = 0;

    gear_edc_adder #(.N(N), .R(R), .P(P)) dut (
        .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .CIN(CIN), .MODE(MODE),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .SUM(SUM), .COUT(COUT),
        .ERR(ERR), .NCORR(NCORR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference built from slice arithmetic and true carries, not from the correction loop.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                  input logic mode, output logic [15:0] s, output logic co,
                                  output logic er, output int nc);
        int ai, bi, ci, mw, mr, mp, t, sa, coa, g, tc, lo, m;
        logic [16:0] ex;
        logic pr;
        ai = int'(a); bi = int'(b); ci = int'(cin);
        mw = (1 << (R + P)) - 1; mr = (1 << R) - 1; mp = (1 << P) - 1;
        ex = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        t = (ai & mw) + (bi & mw) + ci;
        sa = t & mw;
        coa = 0;
        for (int i = 1; i < K; i++) begin
            lo = i * R;
            t = ((ai >> lo) & mw) + ((bi >> lo) & mw);
            sa = sa | (((t >> P) & mr) << (lo + P));
            if (i == K - 1) coa = (t >> (R + P)) & 1;
        end
        er = 1'b0;
        nc = 0;
        for (int i = 1; i < K; i++) begin
            pr = ((((ai ^ bi) >> (i * R)) & mp) == mp);
            g = ((((ai >> ((i - 1) * R)) & mr) + ((bi >> ((i - 1) * R)) & mr)
                 + ((i == 1) ? ci : 0)) >> R) & 1;
            m = (1 << (i * R)) - 1;
            tc = (((ai & m) + (bi & m) + ci) >> (i * R)) & 1;
            if ((g == 1) && pr) er = 1'b1;
            if (mode && (tc == 1) && pr) nc++;
        end
        if (mode) begin
            s = ex[15:0];
            co = ex[16];
        end else begin
            s = 16'(sa);
            co = (coa == 1);
        end
    endfunction

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic mode, input logic [15:0] es,
                         input logic eco, input logic eer, input int enc);
        int n;
        n = 0;
        while (IN_READY !== 1'b1 && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        check({tag, ".in_ready_idle"}, 32'(IN_READY), 32'd1);
        A = a; B = b; CIN = cin; MODE = mode; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        A = 16'($urandom); B = 16'($urandom); CIN = 1'($urandom); MODE = 1'($urandom);
        check({tag, ".in_ready_busy"}, 32'(IN_READY), 32'd0);
        n = 1;
        while (OUT_VALID !== 1'b1 && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(2 + enc));
        check({tag, ".sum"}, 32'(SUM), 32'(es));
        check({tag, ".cout"}, 32'(COUT), 32'(eco));
        check({tag, ".err"}, 32'(ERR), 32'(eer));
        check({tag, ".ncorr"}, 32'(NCORR), 32'(enc));
        repeat ($urandom_range(0, 2)) begin
            @(posedge CLK); #1;
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check({tag, ".out_valid_clr"}, 32'(OUT_VALID), 32'd0);
        check({tag, ".in_ready_back"}, 32'(IN_READY), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb, es;
        logic rc, rm, eco, eer;
        int enc, sel;

        #12;
        check("reset.sum", 32'(SUM), 32'd0);
        check("reset.out_valid", 32'(OUT_VALID), 32'd0);
        check("reset.in_ready", 32'(IN_READY), 32'd1);
        check("reset.ncorr", 32'(NCORR), 32'd0);
        check("reset.err", 32'(ERR), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        do_op("no_err",      16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 0);
        do_op("one_approx",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 0);
        do_op("one_exact",   16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 1);
        do_op("cascade",     16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 2);
        do_op("cascade_apx", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFF00, 1'b0, 1'b1, 0);

        A = 16'h1234; B = 16'h4321; CIN = 1'b0; MODE = 1'b1; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        check("bp.out_valid", 32'(OUT_VALID), 32'd1);
        A = 16'hAAAA; B = 16'h5555; IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("bp.sum_held", 32'(SUM), 32'h5555);
            check("bp.in_ready", 32'(IN_READY), 32'd0);
            check("bp.out_valid_held", 32'(OUT_VALID), 32'd1);
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check("bp.release_ov", 32'(OUT_VALID), 32'd0);
        check("bp.release_ir", 32'(IN_READY), 32'd1);
        @(posedge CLK); #1;
        check("bp.idle_stays", 32'(IN_READY), 32'd1);

        A = 16'hFFFF; B = 16'h0001; CIN = 1'b0; MODE = 1'b1; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        check("rst.mid_ncorr", 32'(NCORR), 32'd1);
        RST_N = 1'b0;
        #2;
        check("rst.sum", 32'(SUM), 32'd0);
        check("rst.cout", 32'(COUT), 32'd0);
        check("rst.err", 32'(ERR), 32'd0);
        check("rst.ncorr", 32'(NCORR), 32'd0);
        check("rst.out_valid", 32'(OUT_VALID), 32'd0);
        check("rst.in_ready", 32'(IN_READY), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        do_op("after_rst", 16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            ra = 16'($urandom);
            if (sel == 0) rb = 16'($urandom);
            else if (sel == 1) rb = ~ra ^ 16'($urandom & 32'h0000_1111);
            else begin
                ra = 16'hFFFF ^ 16'($urandom & 32'h0000_0F0F);
                rb = 16'($urandom_range(1, 15));
            end
            rc = 1'($urandom);
            rm = 1'($urandom);
            model(ra, rb, rc, rm, es, eco, eer, enc);
            do_op("random", ra, rb, rc, rm, es, eco, eer, enc);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
